// File: rtl/tt_capture_pkg.sv
// Shared types and helpers for the truth-table capture block.
package tt_capture_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_SETTLE,
        S_DONE
    } state_e;

    localparam int CNT_W = 4;

    function automatic int tt_width(input int n_in);
        return 2 ** n_in;
    endfunction

endpackage

// File: rtl/tt_capture_if.sv
// Vector-side handshake plus the DUT output sampled by the collector.
interface tt_capture_if #(parameter int N_IN = 3);

    logic [N_IN-1:0] vec;
    logic            vec_valid;
    logic            vec_ready;
    logic            f;

    modport master (output vec, output vec_valid, output f, input vec_ready);
    modport slave  (input vec, input vec_valid, input f, output vec_ready);

endinterface

// File: rtl/tt_settle_cnt.sv
// Loadable down-counter; zero_o marks the cycle whose edge records the sample.
module tt_settle_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tt_capture.sv
// Truth-table collector: accept vector, settle, sample f, tally coverage/mismatches.
// Optional TT_CAPTURE_DUP_CHECK_EN: repeated vectors are flagged instead of overwriting.
module tt_capture
    import tt_capture_pkg::*;
#(
    parameter int                           N_IN     = 3,
    parameter int                           SETTLE   = 2,
    parameter logic [tt_width(N_IN)-1:0]    EXPECTED = 8'hE8,
    localparam int                          TW       = tt_width(N_IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    tt_capture_if.slave     vif,
    output logic [TW-1:0]   tt,
    output logic [TW-1:0]   covered,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mism_cnt,
    output logic [N_IN-1:0] first_mism,
    output logic            first_mism_vld,
    output logic            dup_err
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);
    localparam logic [N_IN:0]    MCNT_MAX = (N_IN + 1)'(TW);
    localparam logic [N_IN:0]    MCNT_ONE = (N_IN + 1)'(1);

    state_e          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [TW-1:0]   tt_q, tt_d;
    logic [TW-1:0]   cov_q, cov_d;
    logic [TW-1:0]   seen_q, seen_d;   // entries already counted as mismatches
    logic [N_IN:0]   mcnt_q, mcnt_d;
    logic [N_IN-1:0] fm_q, fm_d;
    logic            fmv_q, fmv_d;
    logic            dup_q, dup_d;
    logic            cnt_load, cnt_dec, cnt_zero;
    logic            rec_dup, mism;

    tt_settle_cnt #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (LOAD_VAL),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tt_d     = tt_q;
        cov_d    = cov_q;
        seen_d   = seen_q;
        mcnt_d   = mcnt_q;
        fm_d     = fm_q;
        fmv_d    = fmv_q;
        dup_d    = dup_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        rec_dup  = 1'b0;
        mism     = 1'b0;
        if (start) begin
            // start wins over a same-cycle handshake
            state_d = S_COLLECT;
            tt_d    = '0;
            cov_d   = '0;
            seen_d  = '0;
            mcnt_d  = '0;
            fm_d    = '0;
            fmv_d   = 1'b0;
            dup_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_COLLECT: begin
                    if (vif.vec_valid) begin
                        idx_d    = vif.vec;
                        cnt_load = 1'b1;
                        state_d  = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else begin
`ifdef TT_CAPTURE_DUP_CHECK_EN
                        rec_dup = cov_q[idx_q];
                        if (rec_dup) dup_d = 1'b1;
`endif
                        if (!rec_dup) tt_d[idx_q] = vif.f;
                        mism = !rec_dup && (vif.f != EXPECTED[idx_q]) && !seen_q[idx_q];
                        cov_d[idx_q] = 1'b1;
                        if (mism) begin
                            seen_d[idx_q] = 1'b1;
                            if (mcnt_q != MCNT_MAX) mcnt_d = mcnt_q + MCNT_ONE;
                            if (!fmv_q) begin
                                fm_d  = idx_q;
                                fmv_d = 1'b1;
                            end
                        end
                        state_d = (&cov_d) ? S_DONE : S_COLLECT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tt_q    <= '0;
            cov_q   <= '0;
            seen_q  <= '0;
            mcnt_q  <= '0;
            fm_q    <= '0;
            fmv_q   <= 1'b0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tt_q    <= tt_d;
            cov_q   <= cov_d;
            seen_q  <= seen_d;
            mcnt_q  <= mcnt_d;
            fm_q    <= fm_d;
            fmv_q   <= fmv_d;
            dup_q   <= dup_d;
        end
    end

    assign vif.vec_ready  = (state_q == S_COLLECT);
    assign tt             = tt_q;
    assign covered        = cov_q;
    assign done           = &cov_q;
    assign pass           = done && (mcnt_q == '0) && !dup_q;
    assign mism_cnt       = mcnt_q;
    assign first_mism     = fm_q;
    assign first_mism_vld = fmv_q;
    assign dup_err        = dup_q;

endmodule

// File: doc/tt_capture.md
# tt_capture

Response-side collector for exhaustive combinational tests. It accepts applied input vectors over a valid/ready handshake, waits a settle interval, samples the DUT output `f`, and builds the DUT's 2^N_IN-entry truth table. It tracks coverage, counts mismatches against an expected table, and flags completion. It sits on the DUT's output, opposite the vector driver, in self-checking benches and on-chip BIST wrappers.

## Interface
Parameters:
- `N_IN`, 3, DUT input width; the table has 2^N_IN entries.
- `SETTLE`, 2, cycles from vector acceptance to `f` sampling; legal range 1..15.
- `EXPECTED`, 8'hE8, expected truth table, 2^N_IN bits; bit i is the expected `f` for input value i.

Ports:
- `clk` in 1: the single clock; everything is rising-edge.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `start` in 1: one-cycle pulse that clears all results and begins collection.
- `vec` in N_IN: input vector currently applied to the DUT.
- `vec_valid` in 1: `vec` is applied and stable.
- `vec_ready` out 1: collector can accept a vector.
- `f` in 1: DUT output.
- `tt` out 2^N_IN: captured truth table.
- `covered` out 2^N_IN: bit i set once entry i is captured.
- `done` out 1: all entries covered.
- `pass` out 1: equals `done` && `mism_cnt`==0 && !`dup_err`.
- `mism_cnt` out N_IN+1: count of mismatching entries.
- `first_mism` out N_IN: index of the first mismatch.
- `first_mism_vld` out 1: `first_mism` is valid.
- `dup_err` out 1: sticky flag for a repeated vector.

## Operation
- States:
  - IDLE: `vec_ready`=0.
  - COLLECT: `vec_ready`=1.
  - SETTLE: `vec_ready`=0; settle counter runs.
  - DONE: `vec_ready`=0; results hold.
- Transitions:
  - IDLE→COLLECT on `start`.
  - COLLECT→SETTLE on `vec_valid`&&`vec_ready`. The accepted `vec` is latched into `idx`, and the counter loads SETTLE-1.
  - SETTLE: the counter decrements each cycle. On the edge where it reaches 0 (the record edge), `f` is sampled, written into `tt[idx]`, and `covered[idx]` is set. The next state is DONE if `covered` is now all-ones, else COLLECT.
- `start` in any state clears `tt`, `covered`, `mism_cnt`, `first_mism`, `first_mism_vld` and `dup_err`, then enters COLLECT. `start` takes priority over a same-cycle handshake; that vector is not accepted.
- Mismatch at the record edge:
  - Condition: `f` != `EXPECTED[idx]` (and the entry is not a duplicate, see Configuration).
  - `mism_cnt` increments; it saturates at 2^N_IN.
  - If `first_mism_vld`=0, `first_mism`←`idx` and `first_mism_vld`←1.
- Vectors may arrive in any order. `vec` is sampled only at acceptance; changes during SETTLE are ignored.
- DONE holds all results until `start` or reset.

## Timing
- Reset values: state IDLE, `vec_ready`=0, `tt`=0, `covered`=0, `done`=0, `pass`=0, `mism_cnt`=0, `first_mism`=0, `first_mism_vld`=0, `dup_err`=0.
- Accept edge T: the record edge is T+SETTLE. `vec_ready` returns high at T+SETTLE unless the block enters DONE.
- Throughput: one vector per SETTLE+1 cycles.
- `done` rises on the record edge of the last uncovered entry. `pass` is combinational from registered state.
- Reset mid-SETTLE: the partial capture is discarded and all outputs return to their reset values.

## Configuration
- `TT_CAPTURE_DUP_CHECK_EN` defined:
  - A vector whose `covered` bit is already set is still accepted and still settles.
  - At the record edge, `tt` is not written and no mismatch is counted; `dup_err` is set and stays set.
- Undefined:
  - A repeat overwrites `tt[idx]`.
  - A mismatch counts only if that entry has not already been counted as a mismatch.
  - `dup_err` is tied to 0.

## Structure
- Shared package `tt_capture_pkg`: state enum (IDLE, COLLECT, SETTLE, DONE), settle counter width constant (4), and a table-width helper function 2**N_IN.
- One sub-module: `tt_settle_cnt` (load/decrement counter with zero flag).

## Test plan
All cases use N_IN=3, SETTLE=2, EXPECTED=8'hE8.
- Reset then idle: `vec_ready`=0, `tt`=0, `pass`=0; `vec_valid` is ignored.
- `start`, then vectors 0..7 in order driven from the majority function: `tt`=8'hE8, `done`=1, `pass`=1, `mism_cnt`=0. The last record edge falls 23 cycles after the first accept.
- Vectors in order 7,3,5,0,1,2,4,6 with `f` correct except `f`=1 at vector 2: `mism_cnt`=1, `first_mism`=2, `tt`=8'hEC, `pass`=0.
- `vec`=5 sent twice with the macro defined: `dup_err`=1, `covered` has a single bit for entry 5, and `done` still requires all 8 distinct vectors.
- `rst_n` low during SETTLE after 4 captures: all outputs return to reset values. `start` then gives a clean full run with `pass`=1.
- `start` in the same cycle as `vec_valid` in DONE: that vector is not accepted, results clear, and `vec_ready`=1 on the next cycle.
